// File: rtl/demux_pkg.sv
// demux_pkg: shared types and sizing helpers for the TDM frame receiver
package demux_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int FRAME_CNT_W = 16;
  function automatic int slot_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int SLOT_W = slot_w(4);
endpackage

// File: rtl/slot_decoder.sv
// slot_decoder: one-hot decode of the slot being written, gated by enable
module slot_decoder #(
  parameter int SLOT_W = 3,
  parameter int N = 5
) (
  input  logic [SLOT_W-1:0] slot,
  input  logic              en,
  output logic [N-1:0]      oh
);
  // single hot bit selects the staging register that captures this word
  always_comb oh = en ? {{(N-1){1'b0}}, 1'b1} << slot : '0;
endmodule

// File: rtl/demux4_frame_rx.sv
// demux4_frame_rx: TDM frame receiver, distributes frame slots to channel outputs; DEMUX_PARITY_EN adds a trailing XOR parity slot
module demux4_frame_rx
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sync,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     sync_err,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
`ifdef DEMUX_PARITY_EN
  , output logic                   parity_err
`endif
);
  localparam int SW = slot_w(NUM_CH);
`ifdef DEMUX_PARITY_EN
  localparam int LAST = NUM_CH;
`else
  localparam int LAST = NUM_CH - 1;
`endif
  localparam int NST = LAST;
  state_t                   state;
  logic [SW-1:0]            slot_cnt;
  logic [DATA_W-1:0]        stage [NST];
  logic [NUM_CH:0]          oh;
  logic [NUM_CH*DATA_W-1:0] frame;
  logic                     mid, wr_en, last, good;
  logic [SW-1:0]            wr_slot;
  assign mid     = slot_cnt != '0;
  assign wr_en   = in_valid & (in_sync | mid);
  assign wr_slot = in_sync ? '0 : slot_cnt;
  assign last    = |oh[NUM_CH:LAST];
  slot_decoder #(.SLOT_W(SW), .N(NUM_CH + 1)) u_dec (
    .slot(wr_slot),
    .en  (wr_en),
    .oh  (oh)
  );
  // assemble the outgoing frame from staged words and the final data word
  always_comb begin
    frame = '0;
    for (int k = 0; k < NUM_CH - 1; k++) frame[k*DATA_W +: DATA_W] = stage[k];
`ifdef DEMUX_PARITY_EN
    frame[(NUM_CH-1)*DATA_W +: DATA_W] = stage[NUM_CH-1];
`else
    frame[(NUM_CH-1)*DATA_W +: DATA_W] = in_data;
`endif
  end
`ifdef DEMUX_PARITY_EN
  // trailing word must equal the XOR of all staged data words
  always_comb begin
    logic [DATA_W-1:0] par;
    par = '0;
    for (int k = 0; k < NUM_CH; k++) par = par ^ stage[k];
    good = par == in_data;
  end
`else
  assign good = 1'b1;
`endif
  // framing FSM, staging registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < NST; k++) stage[k] <= '0;
`ifdef DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err <= 1'b0;
`endif
      for (int k = 0; k < NST; k++) if (oh[k]) stage[k] <= in_data;
      if (in_valid && in_sync) begin
        sync_err <= mid;
        slot_cnt <= SW'(1);
        state    <= RUN;
      end else if (last) begin
        slot_cnt <= '0;
        if (good) begin
          out_valid <= 1'b1;
          out_data  <= frame;
          frame_cnt <= &frame_cnt ? frame_cnt : frame_cnt + 1'b1;
        end
`ifdef DEMUX_PARITY_EN
        parity_err <= !good;
`endif
      end else if (wr_en) begin
        slot_cnt <= slot_cnt + 1'b1;
      end else if (in_valid && state == RUN) begin
        sync_err <= 1'b1;
        state    <= IDLE;
      end
    end
  end
endmodule
